// File: rtl/block_map_ctrl.sv
// Tile-map write sequencer: streams a full level from ROM into the tile array
// and arbitrates single-tile rewrites from game logic onto the same write bus.
module block_map_ctrl #(
    parameter int COLS        = 20,
    parameter int ROWS        = 15,
    parameter int ID_W        = 4,
    parameter int ADDR_W      = 12,
    parameter int ROM_LATENCY = 2,
    localparam int TILES      = COLS * ROWS,
    localparam int IDX_W      = $clog2(TILES),
    localparam int COL_W      = $clog2(COLS),
    localparam int ROW_W      = $clog2(ROWS)
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              load_start,
    input  logic [ADDR_W-1:0] load_base,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [ID_W-1:0]   rom_data,
    input  logic              upd_req,
    input  logic [COL_W-1:0]  upd_col,
    input  logic [ROW_W-1:0]  upd_row,
    input  logic [ID_W-1:0]   upd_id,
    output logic              upd_ack,
    output logic              change_id,
    output logic [IDX_W-1:0]  tile_sel,
    output logic [ID_W-1:0]   new_block_id,
    output logic              busy,
    output logic              load_done
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TILES - 1);
    localparam logic [COL_W:0]   COLS_L   = (COL_W + 1)'(COLS);
    localparam logic [ROW_W:0]   ROWS_L   = (ROW_W + 1)'(ROWS);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_UPD  = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic              start_load;
    logic              vld_p0;
    logic [IDX_W-1:0]  idx_p0;
    logic              vld_tail;
    logic [IDX_W-1:0]  idx_tail;
    logic              upd_in_range;
    logic [IDX_W-1:0]  upd_idx;
    logic              chg_d, ack_d, done_d, ldwr_d;
    logic [IDX_W-1:0]  sel_d;
    logic [ID_W-1:0]   id_d;
    logic              ld_wr;
    logic [ID_W-1:0]   id_q;

    function automatic logic [IDX_W-1:0] tile_index(input logic [ROW_W-1:0] row,
                                                     input logic [COL_W-1:0] col);
        return IDX_W'(row) * IDX_W'(COLS) + IDX_W'(col);
    endfunction

    assign start_load   = (state == S_IDLE) && load_start;
    assign upd_in_range = ({1'b0, upd_col} < COLS_L) && ({1'b0, upd_row} < ROWS_L);
    assign upd_idx      = tile_index(upd_row, upd_col);

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Requests are refused while upd_ack is high so a still-held request is not served twice.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (load_start)                state_nxt = S_LOAD;
                else if (upd_req && !upd_ack)  state_nxt = S_UPD;
            end
            S_LOAD:  if (load_done) state_nxt = S_IDLE;
            S_UPD:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Stage p0: ROM address issue, one tile per cycle
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            vld_p0   <= 1'b0;
            idx_p0   <= '0;
            rom_addr <= '0;
        end else if (start_load) begin
            vld_p0   <= 1'b1;
            idx_p0   <= '0;
            rom_addr <= load_base;
        end else if (vld_p0 && idx_p0 != LAST_IDX) begin
            idx_p0   <= idx_p0 + IDX_W'(1);
            rom_addr <= rom_addr + ADDR_W'(1);
        end else begin
            vld_p0   <= 1'b0;
        end
    end

    // Stages p1..: tile index rides alongside the ROM read until its data returns
    generate
        if (ROM_LATENCY == 1) begin : g_lat1
            assign vld_tail = vld_p0;
            assign idx_tail = idx_p0;
        end else begin : g_latn
            logic [ROM_LATENCY-2:0] vld_p;
            logic [IDX_W-1:0]       idx_p [ROM_LATENCY-1];

            always_ff @(posedge Clk or negedge Reset) begin
                if (!Reset) begin
                    vld_p <= '0;
                end else begin
                    vld_p[0] <= vld_p0;
                    for (int i = 1; i < ROM_LATENCY - 1; i++) vld_p[i] <= vld_p[i-1];
                end
            end

            always_ff @(posedge Clk) begin
                idx_p[0] <= idx_p0;
                for (int i = 1; i < ROM_LATENCY - 1; i++) idx_p[i] <= idx_p[i-1];
            end

            assign vld_tail = vld_p[ROM_LATENCY-2];
            assign idx_tail = idx_p[ROM_LATENCY-2];
        end
    endgenerate

    always_comb begin
        chg_d  = 1'b0;
        ack_d  = 1'b0;
        done_d = 1'b0;
        ldwr_d = 1'b0;
        sel_d  = tile_sel;
        id_d   = ld_wr ? rom_data : id_q;
        case (state)
            S_LOAD: begin
                if (vld_tail) begin
                    chg_d  = 1'b1;
                    ldwr_d = 1'b1;
                    sel_d  = idx_tail;
                    done_d = (idx_tail == LAST_IDX);
                end
            end
            S_UPD: begin
                ack_d = 1'b1;
                if (upd_in_range) begin
                    chg_d = 1'b1;
                    sel_d = upd_idx;
                    id_d  = upd_id;
                end
            end
            default: ;
        endcase
    end

    // Write-bus stage: registered strobes and index
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            change_id <= 1'b0;
            upd_ack   <= 1'b0;
            load_done <= 1'b0;
            busy      <= 1'b0;
            ld_wr     <= 1'b0;
            tile_sel  <= '0;
            id_q      <= '0;
        end else begin
            change_id <= chg_d;
            upd_ack   <= ack_d;
            load_done <= done_d;
            busy      <= (state_nxt == S_LOAD);
            ld_wr     <= ldwr_d;
            tile_sel  <= sel_d;
            id_q      <= id_d;
        end
    end

    // Load writes forward ROM data straight through; id_q keeps the last value otherwise.
    assign new_block_id = ld_wr ? rom_data : id_q;

endmodule

// File: tb/tb_block_map_ctrl.sv
// Bench for block_map_ctrl: timeline reference model of expected bus activity,
// ROM stub with fixed latency, directed scenarios plus randomized traffic.
module tb_block_map_ctrl;

    localparam int COLS   = 20;
    localparam int ROWS   = 15;
    localparam int ID_W   = 4;
    localparam int ADDR_W = 12;
    localparam int LAT    = 2;
    localparam int TILES  = COLS * ROWS;
    localparam int IDX_W  = $clog2(TILES);
    localparam int COL_W  = $clog2(COLS);
    localparam int ROW_W  = $clog2(ROWS);
    localparam int MAXC   = 20000;

    logic              Clk = 1'b0;
    logic              Reset = 1'b0;
    logic              load_start = 1'b0;
    logic [ADDR_W-1:0] load_base = '0;
    logic [ADDR_W-1:0] rom_addr;
    logic [ID_W-1:0]   rom_data;
    logic              upd_req = 1'b0;
    logic [COL_W-1:0]  upd_col = '0;
    logic [ROW_W-1:0]  upd_row = '0;
    logic [ID_W-1:0]   upd_id = '0;
    logic              upd_ack;
    logic              change_id;
    logic [IDX_W-1:0]  tile_sel;
    logic [ID_W-1:0]   new_block_id;
    logic              busy;
    logic              load_done;

    block_map_ctrl #(
        .COLS(COLS), .ROWS(ROWS), .ID_W(ID_W), .ADDR_W(ADDR_W), .ROM_LATENCY(LAT)
    ) dut (
        .Clk(Clk), .Reset(Reset),
        .load_start(load_start), .load_base(load_base),
        .rom_addr(rom_addr), .rom_data(rom_data),
        .upd_req(upd_req), .upd_col(upd_col), .upd_row(upd_row), .upd_id(upd_id),
        .upd_ack(upd_ack), .change_id(change_id), .tile_sel(tile_sel),
        .new_block_id(new_block_id), .busy(busy), .load_done(load_done)
    );

    always #5 Clk = ~Clk;

    // ROM stub: content is the low address nibble xor a per-load salt
    logic [3:0] salt = 4'd0;
    logic [3:0] rom_pipe [LAT];

    function automatic logic [3:0] rom_fn(input logic [ADDR_W-1:0] a);
        return a[3:0] ^ salt;
    endfunction

    always @(posedge Clk) begin
        rom_pipe[0] <= rom_fn(rom_addr);
        for (int i = 1; i < LAT; i++) rom_pipe[i] <= rom_pipe[i-1];
    end
    assign rom_data = rom_pipe[LAT-1];

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;

    task automatic chk(input string nm, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s at cycle %0d: actual %0d, required %0d", nm, cyc, act, req);
        end
    endtask

    // Reference model: expected output timeline indexed by cycle number
    bit exp_chg  [MAXC];
    bit exp_ack  [MAXC];
    bit exp_done [MAXC];
    bit exp_busy [MAXC];
    bit exp_av   [MAXC];
    int exp_sel  [MAXC];
    int exp_id   [MAXC];
    int exp_addr [MAXC];
    int busy_end = -1;
    int last_acc = -100;

    task automatic sched_load(input int e, input logic [ADDR_W-1:0] base);
        logic [ADDR_W-1:0] a;
        for (int k = 0; k < TILES; k++) begin
            a = base + ADDR_W'(k);
            if (e + k + LAT < MAXC) begin
                exp_av[e+k]       = 1'b1;
                exp_addr[e+k]     = int'(a);
                exp_chg[e+k+LAT]  = 1'b1;
                exp_sel[e+k+LAT]  = k;
                exp_id[e+k+LAT]   = int'(rom_fn(a));
            end
        end
        for (int j = 0; j < TILES + LAT; j++)
            if (e + j < MAXC) exp_busy[e+j] = 1'b1;
        if (e + TILES - 1 + LAT < MAXC) exp_done[e+TILES-1+LAT] = 1'b1;
        busy_end = e + TILES - 1 + LAT;
    endtask

    task automatic sched_upd(input int e, input int c, input int r, input int id);
        last_acc = e;
        if (e + 1 < MAXC) begin
            exp_ack[e+1] = 1'b1;
            if (c < COLS && r < ROWS) begin
                exp_chg[e+1] = 1'b1;
                exp_sel[e+1] = r * COLS + c;
                exp_id[e+1]  = id;
            end
        end
    endtask

    // Edge E sees inputs of cycle E-1; the controller is free if cycle E-1 was
    // neither a load cycle nor the update cycle; updates also skip the ack cycle.
    always @(posedge Clk) begin
        cyc = cyc + 1;
        if (Reset && (cyc - 1 > busy_end) && (cyc - 1 != last_acc)) begin
            if (load_start)
                sched_load(cyc, load_base);
            else if (upd_req && (cyc - 1 != last_acc + 1))
                sched_upd(cyc, int'(upd_col), int'(upd_row), int'(upd_id));
        end
    end

    always @(negedge Reset) begin
        for (int i = cyc; i < MAXC; i++) begin
            exp_chg[i] = 1'b0; exp_ack[i] = 1'b0; exp_done[i] = 1'b0;
            exp_busy[i] = 1'b0; exp_av[i] = 1'b0;
        end
        busy_end = -1;
        last_acc = -100;
    end

    // Monitor counters used by the hand-computed expectations
    int wr_cnt, busy_cnt, done_cnt, ack_cnt;
    int first_sel, last_sel, done_sel, done_cyc, ack_cyc;
    int tile_map [TILES];

    task automatic clear_mon();
        wr_cnt = 0; busy_cnt = 0; done_cnt = 0; ack_cnt = 0;
        first_sel = -1; last_sel = -1; done_sel = -1; done_cyc = -1; ack_cyc = -1;
    endtask

    always @(negedge Clk) begin
        if (cyc < MAXC) begin
            if (!Reset) begin
                chk("rst_change_id", int'(change_id), 0);
                chk("rst_upd_ack", int'(upd_ack), 0);
                chk("rst_busy", int'(busy), 0);
                chk("rst_load_done", int'(load_done), 0);
                chk("rst_tile_sel", int'(tile_sel), 0);
                chk("rst_new_block_id", int'(new_block_id), 0);
                chk("rst_rom_addr", int'(rom_addr), 0);
            end else begin
                chk("change_id", int'(change_id), int'(exp_chg[cyc]));
                chk("upd_ack", int'(upd_ack), int'(exp_ack[cyc]));
                chk("busy", int'(busy), int'(exp_busy[cyc]));
                chk("load_done", int'(load_done), int'(exp_done[cyc]));
                if (exp_chg[cyc]) begin
                    chk("tile_sel", int'(tile_sel), exp_sel[cyc]);
                    chk("new_block_id", int'(new_block_id), exp_id[cyc]);
                end
                if (exp_av[cyc]) chk("rom_addr", int'(rom_addr), exp_addr[cyc]);
            end
        end
        if (Reset) begin
            if (change_id) begin
                if (wr_cnt == 0) first_sel = int'(tile_sel);
                wr_cnt++;
                last_sel = int'(tile_sel);
                if (int'(tile_sel) < TILES) tile_map[tile_sel] = int'(new_block_id);
            end
            if (busy) busy_cnt++;
            if (load_done) begin done_cnt++; done_sel = int'(tile_sel); done_cyc = cyc; end
            if (upd_ack) begin ack_cnt++; ack_cyc = cyc; end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    task automatic do_load(input logic [ADDR_W-1:0] b);
        load_base  = b;
        load_start = 1'b1;
        tick(1);
        load_start = 1'b0;
    endtask

    task automatic wait_done();
        bit seen = 1'b0;
        for (int i = 0; i < TILES + LAT + 20 && !seen; i++) begin
            @(negedge Clk);
            if (load_done) seen = 1'b1;
        end
        chk("load_done_timeout", int'(seen), 1);
        tick(1);
    endtask

    task automatic do_upd(input int c, input int r, input int id);
        bit seen = 1'b0;
        upd_col = COL_W'(c);
        upd_row = ROW_W'(r);
        upd_id  = ID_W'(id);
        upd_req = 1'b1;
        for (int i = 0; i < 2000 && !seen; i++) begin
            @(negedge Clk);
            if (upd_ack) seen = 1'b1;
        end
        chk("upd_ack_timeout", int'(seen), 1);
        tick(1);
        upd_req = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, required $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        int ch;
        clear_mon();
        tick(3);
        Reset = 1'b1;

        clear_mon();
        tick(10);
        chk("idle_no_write", wr_cnt, 0);

        // Update col 3, row 2 -> tile 43
        clear_mon();
        do_upd(3, 2, 5);
        tick(2);
        chk("upd_write_count", wr_cnt, 1);
        chk("upd_ack_count", ack_cnt, 1);
        chk("upd_tile_sel", last_sel, 43);
        chk("upd_map_43", tile_map[43], 5);

        // Asynchronous reset mid-cycle while tile_sel/new_block_id hold 43/5
        #2 Reset = 1'b0;
        #1;
        chk("arst_tile_sel", int'(tile_sel), 0);
        chk("arst_new_block_id", int'(new_block_id), 0);
        chk("arst_change_id", int'(change_id), 0);
        chk("arst_upd_ack", int'(upd_ack), 0);
        chk("arst_busy", int'(busy), 0);
        chk("arst_load_done", int'(load_done), 0);
        tick(2);
        Reset = 1'b1;
        tick(2);

        // Out-of-range updates are acknowledged but not written
        clear_mon();
        do_upd(20, 0, 7);
        tick(2);
        chk("oor_col_ack", ack_cnt, 1);
        chk("oor_col_write", wr_cnt, 0);
        clear_mon();
        do_upd(0, 15, 7);
        tick(2);
        chk("oor_row_ack", ack_cnt, 1);
        chk("oor_row_write", wr_cnt, 0);

        // Full load from 0x100
        salt = 4'd0;
        clear_mon();
        do_load(12'h100);
        wait_done();
        tick(3);
        chk("load_write_count", wr_cnt, 300);
        chk("load_busy_cycles", busy_cnt, 302);
        chk("load_done_count", done_cnt, 1);
        chk("load_done_sel", done_sel, 299);
        chk("load_first_sel", first_sel, 0);
        chk("load_map_7", tile_map[7], 7);
        chk("load_map_299", tile_map[299], 11);

        // Simultaneous load_start and upd_req: load first, then the update
        clear_mon();
        fork
            do_load(12'h100);
            do_upd(0, 0, 9);
        join
        tick(3);
        chk("prio_done_count", done_cnt, 1);
        chk("prio_write_count", wr_cnt, 301);
        chk("prio_ack_count", ack_cnt, 1);
        chk("prio_ack_delay", ack_cyc - done_cyc, 3);
        chk("prio_map_0", tile_map[0], 9);

        // Reset during tile 150, then restart
        clear_mon();
        do_load(12'h037);
        seen = 1'b0;
        for (int i = 0; i < 400 && !seen; i++) begin
            @(negedge Clk);
            if (change_id && tile_sel == IDX_W'(150)) seen = 1'b1;
        end
        chk("tile150_reached", int'(seen), 1);
        #2 Reset = 1'b0;
        #1;
        chk("midload_busy", int'(busy), 0);
        chk("midload_change_id", int'(change_id), 0);
        chk("midload_rom_addr", int'(rom_addr), 0);
        tick(2);
        Reset = 1'b1;
        tick(5);
        chk("midload_no_done", done_cnt, 0);
        clear_mon();
        do_load(12'h037);
        wait_done();
        tick(2);
        chk("restart_first_sel", first_sel, 0);
        chk("restart_write_count", wr_cnt, 300);

        // Address wrap at the top of ROM space
        salt = 4'd5;
        do_load(12'hFF0);
        wait_done();
        tick(2);

        // Randomized traffic
        for (int it = 0; it < 20; it++) begin
            ch = int'($urandom_range(0, 9));
            if (ch <= 2) begin
                salt = 4'($urandom);
                if ($urandom_range(0, 1) == 1) begin
                    fork
                        do_load(12'($urandom));
                        do_upd(int'($urandom_range(0, 23)), int'($urandom_range(0, 15)),
                               int'($urandom_range(0, 15)));
                    join
                end else begin
                    do_load(12'($urandom));
                    tick(int'($urandom_range(5, 250)));
                    load_base  = 12'($urandom);
                    load_start = 1'b1;
                    tick(1);
                    load_start = 1'b0;
                    wait_done();
                end
                tick(2);
            end else if (ch <= 8) begin
                do_upd(int'($urandom_range(0, 23)), int'($urandom_range(0, 15)),
                       int'($urandom_range(0, 15)));
                tick(int'($urandom_range(0, 3)));
            end else begin
                do_load(12'($urandom));
                tick(int'($urandom_range(10, 290)));
                #2 Reset = 1'b0;
                tick(2);
                Reset = 1'b1;
                tick(2);
            end
        end
        tick(5);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
